yuv422_fb_writer: RTL
=====================

// Module: yuv422_fb_writer
// PURPOSE
//  Write-side front end of the YUV422 framebuffer. Takes a 4:4:4 YCbCr pixel stream
//  (valid/ready, SOF on tuser, EOL on tlast) and writes one {Y,Cb,Cr} word per pixel.
//  Chroma is decimated 2:1 by averaging each even/odd pixel pair.
//  Sits between the video source (capture/pattern gen) and the framebuffer write port.
// PARAMETERS
//  H_ACTIVE  1280  active pixels per line; must be even
//  V_ACTIVE  760   active lines per frame
//  PIXELS    H_ACTIVE*V_ACTIVE  (localparam); ADR_BITS = $clog2(PIXELS) (localparam)
// PORTS
//  clk_i         in   1         pixel/fb clock
//  rst_i         in   1         synchronous, active-high reset
//  arm_i         in   1         1-cycle pulse: capture next frame (single-shot mode)
//  cont_i        in   1         1 = capture every frame; 0 = single-shot via arm_i
//  s_tdata_i     in   24        {Y[23:16], Cb[15:8], Cr[7:0]}
//  s_tuser_i     in   1         start of frame (first pixel of line 0)
//  s_tlast_i     in   1         last pixel of line
//  s_tvalid_i    in   1         pixel valid
//  s_tready_o    out  1         always 1 out of reset; 0 during reset
//  wr_addr_o     out  ADR_BITS  framebuffer pixel address, y*H_ACTIVE+x
//  wr_d_o        out  24        {Y, Cb, Cr}; framebuffer word packing
//  wr_en_o       out  1         framebuffer write strobe
//  frame_done_o  out  1         1-cycle pulse together with the last write of a frame
//  err_o         out  3         sticky {sof_mid_frame, line_long, line_short}; cleared by arm_i or reset
// BEHAVIOUR
//  - Reset: state IDLE, x=y=0, wr_en_o=0, wr_addr_o=0, wr_d_o=0, frame_done_o=0, err_o=0, s_tready_o=0.
//  - Beat = s_tvalid_i & s_tready_o. Beats in IDLE/WAIT_SOF/DROP are consumed and discarded.
//  - FSM: IDLE -> WAIT_SOF on arm_i or cont_i=1. WAIT_SOF -> ACTIVE on beat with tuser (that beat is
//    pixel 0, written). ACTIVE -> DROP on line_long. ACTIVE -> WAIT_SOF (cont_i=1) or IDLE after the
//    last frame pixel (x=H_ACTIVE-1, y=V_ACTIVE-1). DROP -> ACTIVE after the beat with tlast.
//  - Latency: registered output, every accepted ACTIVE beat produces wr_en_o=1 exactly 1 cycle later.
//  - Chroma: even x writes {Y, Cb, Cr} of that pixel and holds Cb/Cr. Odd x writes
//    {Y, (Cb_e+Cb_o+1)>>1, (Cr_e+Cr_o+1)>>1}, 9-bit sum, round-half-up. The shared CbCr word is
//    overwritten by the odd write, so the stored pair is the average.
//  - Address increments by 1 per written pixel. At end of line, x=0 and y+1.
//  - tlast with x<H_ACTIVE-1: set line_short. Next beat starts the next line at (y+1)*H_ACTIVE.
//    Same frame-end rule applies if y=V_ACTIVE-1.
//  - x=H_ACTIVE-1 beat without tlast: write it, set line_long. Go to DROP until tlast.
//    The line still counts as complete.
//  - tuser in ACTIVE with (x,y)!=(0,0): set sof_mid_frame. Restart at addr 0 with that beat written.
//  - Odd pixel after short-line resync: no even partner, so it uses its own chroma (no averaging).
//  - arm_i while ACTIVE: ignored except that it clears err_o. cont_i falling mid-frame: the frame completes, then IDLE.
//  - Reset mid-frame: the next write occurs only after a new arm/cont and tuser.
//    Framebuffer contents are not cleared.
// STRUCTURE
//  - Package yuv422_pkg: typedef ycbcr_t (packed {y,cb,cr}, 8b each); enum wr_state_e
//    {IDLE, WAIT_SOF, ACTIVE, DROP}; function chroma_avg(8b,8b)->8b; ERR_* bit index constants.
//  - Single flat module: FSM, x/y/addr counters, chroma hold register, output register.
//  - No sub-module. Instantiated beside yuv422_fb, driving its write port.
// TESTING
//  1 Full 1280x760 ramp frame, cont_i=1 -> 972800 writes, addr 0..972799 in order, one frame_done_o
//    on the final write, err_o=0.
//  2 Pixel pair Cb=8'd10/8'd13, Cr=8'd200/8'd201 -> odd write carries Cb=12, Cr=201.
//    Readback via yuv422_fb shows them.
//  3 Line 3 ends with tlast at x=99 -> err_o=3'b001. The next pixel is written at addr 4*1280.
//    The frame still ends with frame_done_o.
//  4 tuser injected at line 5 x=40 -> err_o[2]=1. That pixel is written at addr 0 and the counters restart.
//  5 cont_i=0, no arm_i: stream one frame -> no writes. Pulse arm_i -> exactly the next frame is
//    written, then IDLE.
//  6 rst_i asserted for 1 cycle mid-line -> the next cycle has wr_en_o=0 and s_tready_o=0.
//    After re-arm, writing resumes at addr 0 only on tuser.

Source files
------------

// File: rtl/yuv422_pkg.sv
// Shared types and helpers for the YUV422 framebuffer write path.
//   ycbcr_t    : packed {y, cb, cr}, 8 bits each (matches framebuffer word packing)
//   wr_state_e : writer FSM states
//   chroma_avg : 2:1 chroma decimation, round-half-up on a 9-bit sum
//   ERR_*      : bit positions inside the writer's sticky error vector
package yuv422_pkg;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycbcr_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    DROP     = 2'd3
  } wr_state_e;

  localparam int ERR_LINE_SHORT = 0;
  localparam int ERR_LINE_LONG  = 1;
  localparam int ERR_SOF_MID    = 2;

  function automatic logic [7:0] chroma_avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b} + 9'd1;
    return sum[8:1];
  endfunction

endpackage

// File: rtl/yuv422_fb_writer.sv
// Write-side front end of the YUV422 framebuffer.
// Accepts a 4:4:4 YCbCr stream (valid/ready, SOF on tuser, EOL on tlast) and emits one
// registered framebuffer write per accepted pixel, averaging chroma over even/odd pairs.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   arm_i, cont_i           single-shot arm pulse / continuous capture enable
//   s_t*_i, s_tready_o      pixel stream in ({Y,Cb,Cr}, SOF, EOL, valid) and ready
//   wr_addr_o/wr_d_o/wr_en_o framebuffer write port (address y*H_ACTIVE+x)
//   frame_done_o            pulses with the last write of a frame
//   err_o                   sticky {sof_mid_frame, line_long, line_short}
//
// state    | meaning
// IDLE     | not capturing; beats discarded
// WAIT_SOF | armed; beats discarded until one carries tuser
// ACTIVE   | writing pixels of the current frame
// DROP     | line overran H_ACTIVE; discarding until tlast
module yuv422_fb_writer
  import yuv422_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 760,
  localparam int PIXELS   = H_ACTIVE * V_ACTIVE,
  localparam int ADR_BITS = $clog2(PIXELS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                arm_i,
  input  logic                cont_i,
  input  logic [23:0]         s_tdata_i,
  input  logic                s_tuser_i,
  input  logic                s_tlast_i,
  input  logic                s_tvalid_i,
  output logic                s_tready_o,
  output logic [ADR_BITS-1:0] wr_addr_o,
  output logic [23:0]         wr_d_o,
  output logic                wr_en_o,
  output logic                frame_done_o,
  output logic [2:0]          err_o
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  wr_state_e           state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADR_BITS-1:0] addr_q, addr_d, base_q, base_d;
  logic [7:0]          cb_hold_q, cb_hold_d, cr_hold_q, cr_hold_d;
  logic                pair_q, pair_d;
  logic                rdy_q;
  logic                wr_en_q, wr_en_d, fd_q, fd_d;
  logic [ADR_BITS-1:0] wr_addr_q, wr_addr_d;
  ycbcr_t              wr_d_q, wr_d_d;
  logic [2:0]          err_q, err_d;

  ycbcr_t              pix;
  logic                beat, take, restart, x_last, y_last;
  logic [XW-1:0]       cx;
  logic [YW-1:0]       cy;
  logic [ADR_BITS-1:0] caddr, cbase;

  assign pix  = ycbcr_t'(s_tdata_i);
  assign beat = s_tvalid_i & rdy_q;
  // A tuser beat always starts a frame at (0,0), whether from WAIT_SOF or mid-frame.
  assign take    = beat & ((state_q == ACTIVE) | ((state_q == WAIT_SOF) & s_tuser_i));
  assign restart = s_tuser_i;
  assign cx      = restart ? '0 : x_q;
  assign cy      = restart ? '0 : y_q;
  assign caddr   = restart ? '0 : addr_q;
  assign cbase   = restart ? '0 : base_q;
  assign x_last  = (cx == XW'(H_ACTIVE - 1));
  assign y_last  = (cy == YW'(V_ACTIVE - 1));

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    base_d    = base_q;
    cb_hold_d = cb_hold_q;
    cr_hold_d = cr_hold_q;
    pair_d    = pair_q;
    wr_en_d   = 1'b0;
    fd_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_d_d    = wr_d_q;
    err_d     = arm_i ? 3'b000 : err_q;

    case (state_q)
      IDLE:    if (arm_i || cont_i) state_d = WAIT_SOF;
      DROP:    if (beat && s_tlast_i) state_d = ACTIVE;
      default: ;
    endcase

    if (take) begin
      if (state_q == ACTIVE && s_tuser_i && (x_q != '0 || y_q != '0))
        err_d[ERR_SOF_MID] = 1'b1;
      state_d   = ACTIVE;
      wr_en_d   = 1'b1;
      wr_addr_d = caddr;
      if (!cx[0]) begin
        wr_d_d    = pix;
        cb_hold_d = pix.cb;
        cr_hold_d = pix.cr;
        pair_d    = 1'b1;
      end else begin
        // An odd pixel without an even partner on this line keeps its own chroma.
        wr_d_d.y  = pix.y;
        wr_d_d.cb = pair_q ? chroma_avg(cb_hold_q, pix.cb) : pix.cb;
        wr_d_d.cr = pair_q ? chroma_avg(cr_hold_q, pix.cr) : pix.cr;
        pair_d    = 1'b0;
      end

      if (s_tlast_i && !x_last) err_d[ERR_LINE_SHORT] = 1'b1;
      if (!s_tlast_i && x_last) begin
        err_d[ERR_LINE_LONG] = 1'b1;
        state_d = DROP;
      end

      if (s_tlast_i || x_last) begin
        pair_d = 1'b0;
        x_d    = '0;
        if (y_last) begin
          // Frame end wins over DROP: leftover beats are discarded in WAIT_SOF/IDLE anyway.
          fd_d    = 1'b1;
          state_d = cont_i ? WAIT_SOF : IDLE;
          y_d     = '0;
          addr_d  = '0;
          base_d  = '0;
        end else begin
          y_d    = cy + YW'(1);
          base_d = cbase + ADR_BITS'(H_ACTIVE);
          addr_d = cbase + ADR_BITS'(H_ACTIVE);
        end
      end else begin
        x_d    = cx + XW'(1);
        y_d    = cy;
        base_d = cbase;
        addr_d = caddr + ADR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      base_q    <= '0;
      cb_hold_q <= '0;
      cr_hold_q <= '0;
      pair_q    <= 1'b0;
      rdy_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      fd_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_d_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      cb_hold_q <= cb_hold_d;
      cr_hold_q <= cr_hold_d;
      pair_q    <= pair_d;
      rdy_q     <= 1'b1;
      wr_en_q   <= wr_en_d;
      fd_q      <= fd_d;
      wr_addr_q <= wr_addr_d;
      wr_d_q    <= wr_d_d;
      err_q     <= err_d;
    end
  end

  assign s_tready_o   = rdy_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_d_o       = wr_d_q;
  assign wr_en_o      = wr_en_q;
  assign frame_done_o = fd_q;
  assign err_o        = err_q;

endmodule
